// File: rtl/sram_mem_bridge.sv
// Bridges the core memory port to the SPI SRAM master: one access per request,
// little-endian lane reordering, active-low request sequencing with idle gap.
// Optional watchdog: define SRAM_BRIDGE_TIMEOUT_EN.
module sram_mem_bridge #(
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_mem_valid,
   input  logic        i_mem_we,
   input  logic [1:0]  i_mem_size,
   input  logic [23:0] i_mem_addr,
   input  logic [31:0] i_mem_wdata,
   output logic [31:0] o_mem_rdata,
   output logic        o_mem_ready,
   output logic        o_mem_err,
   output logic        o_spi_req,
   output logic [23:0] o_spi_addr,
   output logic [31:0] o_spi_wdata,
   output logic [1:0]  o_spi_byte_mask,
   output logic        o_spi_write,
   input  logic [31:0] i_spi_rdata,
   input  logic        i_spi_busy,
   input  logic        i_spi_valid
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;

   // DONE already counts as the first high cycle of the gap.
   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

   function automatic logic [1:0] f_mask(input logic [1:0] size);
      case (size)
         2'b00:   f_mask = 2'b00;
         2'b01:   f_mask = 2'b01;
         default: f_mask = 2'b10;
      endcase
   endfunction

   function automatic logic [31:0] f_store_lanes(input logic [1:0] size, input logic [31:0] w);
      case (size)
         2'b00:   f_store_lanes = {w[7:0], 24'h000000};
         2'b01:   f_store_lanes = {w[7:0], w[15:8], 16'h0000};
         default: f_store_lanes = {w[7:0], w[15:8], w[23:16], w[31:24]};
      endcase
   endfunction

   // The master leaves unused low bytes stale, so they are always masked here.
   function automatic logic [31:0] f_load_lanes(input logic [1:0] mask, input logic [31:0] r);
      case (mask)
         2'b00:   f_load_lanes = {24'h000000, r[31:24]};
         2'b01:   f_load_lanes = {16'h0000, r[23:16], r[31:24]};
         default: f_load_lanes = {r[7:0], r[15:8], r[23:16], r[31:24]};
      endcase
   endfunction

   logic [2:0] r_state;
   logic [2:0] w_next;
   logic [7:0] r_gap_cnt;
   logic       w_timeout;
   logic       w_valid_done;

   assign w_valid_done = (r_state == S_RUN) && i_spi_valid;

`ifdef SRAM_BRIDGE_TIMEOUT_EN
   logic [15:0] r_to_cnt;

   // Watchdog counter, zero on every START entry.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_to_cnt <= 16'd0;
      end else if (r_state == S_START || r_state == S_RUN) begin
         r_to_cnt <= r_to_cnt + 16'd1;
      end else begin
         r_to_cnt <= 16'd0;
      end
   end

   assign w_timeout = (r_state == S_START || r_state == S_RUN) &&
                      (r_to_cnt == 16'(TIMEOUT_CYCLES));
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
   assign w_timeout        = 1'b0;
`endif

   // Next-state logic; stale spi_valid from the previous access is ignored in START.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_mem_valid) w_next = S_START; else w_next = S_IDLE;
         S_START: begin
            if (w_timeout)       w_next = S_DONE;
            else if (i_spi_busy) w_next = S_RUN;
            else                 w_next = S_START;
         end
         S_RUN:   if (i_spi_valid || w_timeout) w_next = S_DONE; else w_next = S_RUN;
         S_DONE:  w_next = S_GAP;
         S_GAP:   if (r_gap_cnt >= GAP_LAST) w_next = S_IDLE; else w_next = S_GAP;
         default: w_next = S_IDLE;
      endcase
   end

   // State, registered outputs and request/response capture.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state         <= S_IDLE;
         r_gap_cnt       <= 8'd0;
         o_spi_req       <= 1'b1;
         o_mem_ready     <= 1'b0;
         o_mem_err       <= 1'b0;
         o_mem_rdata     <= 32'h00000000;
         o_spi_addr      <= 24'h000000;
         o_spi_wdata     <= 32'h00000000;
         o_spi_byte_mask <= 2'b00;
         o_spi_write     <= 1'b0;
      end else begin
         r_state     <= w_next;
         o_spi_req   <= !(w_next == S_START || w_next == S_RUN);
         o_mem_ready <= (w_next == S_DONE);
         o_mem_err   <= (w_next == S_DONE) && !w_valid_done;
         if (r_state == S_IDLE && i_mem_valid) begin
            o_spi_addr      <= i_mem_addr;
            o_spi_wdata     <= f_store_lanes(i_mem_size, i_mem_wdata);
            o_spi_byte_mask <= f_mask(i_mem_size);
            o_spi_write     <= i_mem_we;
         end
         if (w_valid_done && !o_spi_write) begin
            o_mem_rdata <= f_load_lanes(o_spi_byte_mask, i_spi_rdata);
         end
         if (r_state == S_DONE) begin
            r_gap_cnt <= 8'd1;
         end else if (r_state == S_GAP) begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
         end else begin
            r_gap_cnt <= r_gap_cnt;
         end
      end
   end

endmodule

// File: tb/tb_sram_mem_bridge.sv
// Directed bench for sram_mem_bridge with a small behavioural SPI SRAM master.
module tb_sram_mem_bridge;

`ifdef SRAM_BRIDGE_TIMEOUT_EN
   localparam int TO_CYC = 50;
`else
   localparam int TO_CYC = 200;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_valid, mem_we;
   logic [1:0]  mem_size;
   logic [23:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_ready, mem_err;
   logic        spi_req, spi_write, spi_busy, spi_valid;
   logic [23:0] spi_addr;
   logic [31:0] spi_wdata, spi_rdata;
   logic [1:0]  spi_byte_mask;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int run_len = 0;
   int last_run = 0;

   always #5 clk = ~clk;

   sram_mem_bridge #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk(clk), .reset(reset),
      .i_mem_valid(mem_valid), .i_mem_we(mem_we), .i_mem_size(mem_size),
      .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
      .o_mem_rdata(mem_rdata), .o_mem_ready(mem_ready), .o_mem_err(mem_err),
      .o_spi_req(spi_req), .o_spi_addr(spi_addr), .o_spi_wdata(spi_wdata),
      .o_spi_byte_mask(spi_byte_mask), .o_spi_write(spi_write),
      .i_spi_rdata(spi_rdata), .i_spi_busy(spi_busy), .i_spi_valid(spi_valid)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Length of the most recent completed high run of spi_req.
   always @(negedge clk) begin
      if (spi_req === 1'b1) begin
         run_len <= run_len + 1;
      end else begin
         if (run_len != 0) last_run <= run_len;
         run_len <= 0;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Behavioural master: busy after a short delay, valid left high until next request.
   logic [7:0] sram [0:1023];
   int  m_phase, m_cnt, m_valid_cyc, m_nb;
   bit  m_stall;
   initial begin
      spi_busy = 1'b0; spi_valid = 1'b0; spi_rdata = 32'hA5A5A5A5;
      m_phase = 0; m_cnt = 0; m_stall = 1'b0; m_valid_cyc = 0; m_nb = 0;
      for (int i = 0; i < 1024; i++) sram[i] = 8'h00;
      forever begin
         @(negedge clk);
         if (spi_req !== 1'b0) begin
            spi_busy = 1'b0;
            m_phase  = 0;
         end else begin
            case (m_phase)
               0: if (m_stall) spi_valid = 1'b0; else m_phase = 1;
               1: begin spi_busy = 1'b1; spi_valid = 1'b0; m_cnt = 6; m_phase = 2; end
               2: begin
                  if (m_cnt == 0) begin
                     m_nb = (spi_byte_mask == 2'b00) ? 1 : (spi_byte_mask == 2'b01) ? 2 : 4;
                     for (int i = 0; i < m_nb; i++) begin
                        if (spi_write) sram[spi_addr[9:0] + 10'(i)] = spi_wdata[31-8*i -: 8];
                        else spi_rdata[31-8*i -: 8] = sram[spi_addr[9:0] + 10'(i)];
                     end
                     spi_busy = 1'b0; spi_valid = 1'b1; m_valid_cyc = cyc; m_phase = 3;
                  end else begin
                     m_cnt--;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   task automatic do_access(input logic we, input logic [1:0] sz, input logic [23:0] addr,
                            input logic [31:0] wd, input bit hold,
                            output logic [31:0] rd, output logic err, output logic [31:0] sw,
                            output logic [1:0] sm, output int acc_lat, output int rdy_lat);
      int  t0;
      bit  got;
      mem_valid = 1'b1; mem_we = we; mem_size = sz; mem_addr = addr; mem_wdata = wd;
      t0 = cyc;
      got = 1'b0;
      for (int n = 0; n < 50 && !got; n++) begin
         @(posedge clk); #1;
         if (spi_req == 1'b0) got = 1'b1;
      end
      check_val("req_low_wait", 32'(got), 32'd1);
      acc_lat = cyc - t0; sw = spi_wdata; sm = spi_byte_mask;
      got = 1'b0;
      for (int n = 0; n < 300 && !got; n++) begin
         @(posedge clk); #1;
         if (mem_ready == 1'b1) got = 1'b1;
      end
      check_val("ready_wait", 32'(got), 32'd1);
      rdy_lat = cyc - t0; rd = mem_rdata; err = mem_err;
      if (!m_stall) check_val("ready_after_valid", 32'(cyc - m_valid_cyc), 32'd1);
      check_val("latency_le_140", 32'(rdy_lat <= 140), 32'd1);
      if (!hold) mem_valid = 1'b0;
      @(posedge clk); #1;
      check_val("ready_pulse", 32'(mem_ready), 32'd0);
   endtask

   logic [31:0] rd, sw;
   logic [1:0]  sm;
   logic        err;
   int          acc, rdy;
   bit          got;

   initial begin
      reset = 1'b0; mem_valid = 1'b0; mem_we = 1'b0; mem_size = 2'b00;
      mem_addr = 24'h0; mem_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_req", 32'(spi_req), 32'd1);
      check_val("rst_ready", 32'(mem_ready), 32'd0);
      check_val("rst_err", 32'(mem_err), 32'd0);
      check_val("rst_rdata", mem_rdata, 32'h0);
      check_val("rst_addr", 32'(spi_addr), 32'h0);
      check_val("rst_wdata", spi_wdata, 32'h0);
      check_val("rst_mask", 32'(spi_byte_mask), 32'd0);
      check_val("rst_write", 32'(spi_write), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Word store then word load
      do_access(1'b1, 2'b10, 24'h000100, 32'h11223344, 1'b0, rd, err, sw, sm, acc, rdy);
      check_val("sw_accept_lat", 32'(acc), 32'd1);
      check_val("sw_wdata", sw, 32'h44332211);
      check_val("sw_mask", 32'(sm), 32'd2);
      check_val("sw_addr", 32'(spi_addr), 32'h000100);
      check_val("sw_dir", 32'(spi_write), 32'd1);
      check_val("sw_err", 32'(err), 32'd0);
      check_val("sram_100", 32'(sram[10'h100]), 32'h44);
      check_val("sram_101", 32'(sram[10'h101]), 32'h33);
      check_val("sram_102", 32'(sram[10'h102]), 32'h22);
      check_val("sram_103", 32'(sram[10'h103]), 32'h11);
      do_access(1'b0, 2'b10, 24'h000100, 32'h0, 1'b0, rd, err, sw, sm, acc, rdy);
      check_val("lw_rdata", rd, 32'h11223344);
      check_val("lw_err", 32'(err), 32'd0);
      check_val("lw_dir", 32'(spi_write), 32'd0);

      // Byte load with stale low bytes in the master
      do_access(1'b0, 2'b00, 24'h000102, 32'h0, 1'b0, rd, err, sw, sm, acc, rdy);
      check_val("lb_mask", 32'(sm), 32'd0);
      check_val("lb_rdata", rd, 32'h00000022);

      // Half store at odd address, then load back
      do_access(1'b1, 2'b01, 24'h000201, 32'h1234BEEF, 1'b0, rd, err, sw, sm, acc, rdy);
      check_val("sh_wdata", sw, 32'hEFBE0000);
      check_val("sh_mask", 32'(sm), 32'd1);
      check_val("sram_201", 32'(sram[10'h201]), 32'hEF);
      check_val("sram_202", 32'(sram[10'h202]), 32'hBE);
      check_val("sram_203", 32'(sram[10'h203]), 32'h00);
      check_val("rdata_hold_store", mem_rdata, 32'h00000022);
      do_access(1'b0, 2'b01, 24'h000201, 32'h0, 1'b0, rd, err, sw, sm, acc, rdy);
      check_val("lh_rdata", rd, 32'h0000BEEF);

      // Back-to-back loads with mem_valid held high
      do_access(1'b0, 2'b10, 24'h000100, 32'h0, 1'b1, rd, err, sw, sm, acc, rdy);
      check_val("b2b_first", rd, 32'h11223344);
      do_access(1'b0, 2'b00, 24'h000202, 32'h0, 1'b0, rd, err, sw, sm, acc, rdy);
      check_val("b2b_second", rd, 32'h000000BE);
      check_val("b2b_gap_len", 32'(last_run), 32'd3);

      // Reset in the middle of a word store
      mem_valid = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 24'h000300;
      mem_wdata = 32'hCAFEF00D;
      got = 1'b0;
      for (int n = 0; n < 50 && !got; n++) begin
         @(posedge clk); #1;
         if (spi_busy == 1'b1) got = 1'b1;
      end
      check_val("busy_wait", 32'(got), 32'd1);
      @(posedge clk); #1;
      reset = 1'b0; mem_valid = 1'b0;
      @(posedge clk); #1;
      check_val("midrst_req", 32'(spi_req), 32'd1);
      check_val("midrst_ready", 32'(mem_ready), 32'd0);
      check_val("midrst_rdata", mem_rdata, 32'h0);
      reset = 1'b1;
      @(posedge clk); #1;
      check_val("midrst_idle_req", 32'(spi_req), 32'd1);
      do_access(1'b0, 2'b10, 24'h000100, 32'h0, 1'b0, rd, err, sw, sm, acc, rdy);
      check_val("postrst_rdata", rd, 32'h11223344);
      check_val("sram_300_untouched", 32'(sram[10'h300]), 32'h00);

`ifdef SRAM_BRIDGE_TIMEOUT_EN
      // Master never responds: watchdog completes the access with an error
      m_stall = 1'b1;
      do_access(1'b0, 2'b10, 24'h000200, 32'h0, 1'b0, rd, err, sw, sm, acc, rdy);
      check_val("to_err", 32'(err), 32'd1);
      check_val("to_rdata_kept", rd, 32'h11223344);
      check_val("to_cycles", 32'(rdy - acc), 32'd51);
      check_val("to_req_high", 32'(spi_req), 32'd1);
      m_stall = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

endmodule

// File: doc/sram_mem_bridge.md
# sram_mem_bridge

Upstream controller between the core's data/instruction memory port and the SPI SRAM master. It accepts one byte/half/word load or store at a time and converts it into a single SPI SRAM transaction. It performs little-endian byte-lane reordering so that bytes land at ascending SRAM addresses, and it sequences the master's active-low request line, including the mandatory idle gap. It returns right-aligned, zero-extended read data with a one-cycle `mem_ready` pulse.

## Interface

Parameters:
- `GAP_CYCLES`, default 2: clk cycles `spi_req` is held high between transactions; minimum legal value is 2.
- `TIMEOUT_CYCLES`, default 200: watchdog limit in clk cycles; only used with `SRAM_BRIDGE_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-low.
- `mem_valid` in 1: request present; held until `mem_ready`.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_size` in 2: 00 byte, 01 half, 10/11 word.
- `mem_addr` in 24: SRAM byte address; any alignment is allowed.
- `mem_wdata` in 32: right-aligned store data.
- `mem_rdata` out 32: right-aligned, zero-extended load data.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_err` out 1: valid with `mem_ready`; 1 = transaction timed out.
- `spi_req` out 1: master request, active-low; 1 = idle/abort.
- `spi_addr` out 24: master address.
- `spi_wdata` out 32: master write data, MSB-first on the wire.
- `spi_byte_mask` out 2: 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes.
- `spi_write` out 1: master direction.
- `spi_rdata` in 32: master read data, left-aligned.
- `spi_busy` in 1: master busy.
- `spi_valid` in 1: master completion.

## Operation

FSM states: IDLE, START, RUN, DONE, GAP.

- **IDLE**
  - `spi_req` = 1.
  - When `mem_valid` = 1, latch `mem_addr`, `mem_we`, `mem_size` and the reordered `mem_wdata` into the `spi_*` output registers, then go to START.
- **START**
  - `spi_req` = 0.
  - Wait for `spi_busy` = 1, then go to RUN.
  - `spi_valid` is ignored in START, because a stale VALID from the previous transaction may still be present.
- **RUN**
  - `spi_req` = 0.
  - On `spi_valid` = 1, go to DONE.
- **DONE** (one cycle)
  - `spi_req` = 1 and `mem_ready` = 1.
  - If a load, `mem_rdata` is loaded with the reordered `spi_rdata`.
  - Next state is GAP.
- **GAP**
  - `spi_req` = 1 for `GAP_CYCLES` cycles, counted from the DONE cycle inclusive, then return to IDLE.
  - `mem_valid` is not sampled during GAP.

Store lane mapping (w = `mem_wdata`):
- Byte: `spi_wdata` = {w[7:0], 24'h0}.
- Half: `spi_wdata` = {w[7:0], w[15:8], 16'h0}.
- Word: `spi_wdata` = {w[7:0], w[15:8], w[23:16], w[31:24]}.

Load mapping (r = `spi_rdata`):
- Byte: `mem_rdata` = {24'h0, r[31:24]}.
- Half: `mem_rdata` = {16'h0, r[23:16], r[31:24]}.
- Word: `mem_rdata` = {r[7:0], r[15:8], r[23:16], r[31:24]}.
- Unused master bits are always masked, because the master does not clear them.

Boundary rules:
- `spi_*` request outputs are stable from the IDLE→START edge through DONE.
- If `mem_valid` drops mid-transaction, the transaction still completes and `mem_ready` still pulses. This is a protocol violation that the bridge tolerates, not supports.
- A new request asserted during DONE/GAP waits; it is accepted in IDLE.
- `mem_rdata` holds its value across stores and idle periods.
- Reset mid-transaction: IDLE next cycle with `spi_req` = 1, which aborts the master.

## Timing

- Reset values:
  - State IDLE.
  - `spi_req` = 1.
  - `mem_ready` = 0, `mem_err` = 0, `mem_rdata` = 0.
  - `spi_addr` = 0, `spi_wdata` = 0, `spi_byte_mask` = 0, `spi_write` = 0.
- Acceptance: `mem_valid` sampled high in IDLE → `spi_req` low on the next cycle.
- Completion: `mem_ready` is asserted exactly 1 cycle after `spi_valid` is first sampled high in RUN.
- Word access end-to-end, `mem_valid` to `mem_ready`: ≤ 140 clk. This is the SPI bit time of 8 + 24 + 32 bits at 2 clk/bit plus overhead.
- Back-to-back throughput: the next acceptance is no earlier than `GAP_CYCLES` cycles after `mem_ready`.

## Configuration

`SRAM_BRIDGE_TIMEOUT_EN`
- **Defined:** a 16-bit counter clears at START entry and increments in START/RUN. On reaching `TIMEOUT_CYCLES`, the bridge goes to DONE with `mem_err` = 1, `mem_rdata` unchanged, and `spi_req` = 1, which aborts the master, then GAP as normal.
- **Undefined:** no counter is built, `mem_err` is tied 0, and the bridge waits indefinitely for `spi_valid`.

## Test plan

- Store word 0x11223344 at 0x000100, then load word at 0x000100 → SRAM bytes 0x100..0x103 = 44,33,22,11; load returns `mem_rdata` = 0x11223344 with `mem_err` = 0.
- Load byte at 0x000102 after the previous scenario → `spi_byte_mask` = 00; `mem_rdata` = 0x00000022 even though the master's lower bits still hold stale data.
- Store half 0xBEEF at odd address 0x000201, then load half → `mem_rdata` = 0x0000BEEF; SRAM 0x201 = EF, 0x202 = BE.
- Two back-to-back loads with `mem_valid` held high → `spi_req` is high for ≥ 2 cycles between them; the second completion is not triggered by the stale `spi_valid`.
- `reset` = 0 during RUN of a word store → next cycle `spi_req` = 1, state IDLE, `mem_ready` = 0; a subsequent load completes normally.
- With `SRAM_BRIDGE_TIMEOUT_EN` defined, `TIMEOUT_CYCLES` = 50, and `spi_busy`/`spi_valid` held 0 → `mem_ready` = 1 with `mem_err` = 1 at cycle 51 after START, then `spi_req` = 1.
